// File: rtl/waveform_defs.sv
// Shared LUT geometry and loader state encodings for the waveform loader.
package waveform_defs;

    localparam int LUT_ADDR_W       = 14;
    localparam int LUT_DEPTH        = 1 << LUT_ADDR_W;
    localparam int ENTRY_W          = 2;
    localparam int ENTRIES_PER_BYTE = 8 / ENTRY_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Entry i of a packed byte sits at bits [2i+1:2i], LSB pair first.
    function automatic logic [ENTRY_W-1:0] slot_entry(input logic [7:0] b, input logic [1:0] slot);
        return b[{slot, 1'b0} +: ENTRY_W];
    endfunction

endpackage

// File: rtl/wave_byte_unpack.sv
// Byte holding register that emits its four 2-bit entries one per cycle,
// and takes the next byte on the same cycle its last entry goes out.
module wave_byte_unpack
    import waveform_defs::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic               i_clear,
    input  logic               i_last,
    input  logic               i_valid,
    input  logic [7:0]         i_data,
    output logic               o_ready,
    output logic               o_accept,
    output logic               o_wr,
    output logic [ENTRY_W-1:0] o_entry
);

    logic [7:0] r_buf;
    logic [1:0] r_slot;
    logic       r_full;
    logic       w_slot3;

    assign w_slot3  = (r_slot == 2'd3);
    assign o_wr     = i_en & r_full;
    // Refill overlaps the slot-3 write, except on the final table entry.
    assign o_ready  = i_en & (~r_full | (w_slot3 & ~i_last));
    assign o_accept = o_ready & i_valid;
    assign o_entry  = slot_entry(r_buf, r_slot);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_buf  <= 8'h00;
            r_slot <= 2'd0;
            r_full <= 1'b0;
        end else if (o_accept) begin
            r_buf  <= i_data;
            r_slot <= 2'd0;
            r_full <= 1'b1;
        end else if (o_wr) begin
            r_slot <= r_slot + 2'd1;
            if (w_slot3)
                r_full <= 1'b0;
        end
    end

endmodule

// File: rtl/waveform_loader.sv
// Streams packed waveform bytes into the LUT B port, tracks checksum and validity.
// Optional readback verify pass is built when WAVEFORM_VERIFY_EN is defined.
module waveform_loader
    import waveform_defs::*;
#(
    parameter int ADDR_W = LUT_ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [7:0]         s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic               lut_we,
    output logic [ADDR_W-1:0]  lut_addr,
    output logic [ENTRY_W-1:0] lut_din,
    input  logic [ENTRY_W-1:0] lut_dout,
    output logic               busy,
    output logic               done,
    output logic               table_valid,
    output logic               error,
    output logic [15:0]        checksum
);

    state_t             r_state, w_next;
    logic [ADDR_W-1:0]  r_addr;
    logic [15:0]        r_checksum;
    logic               r_table_valid;
    logic               w_busy, w_done;
    logic               w_start_ok, w_abort, w_clear, w_last;
    logic               w_wr, w_accept, w_en;
    logic [ENTRY_W-1:0] w_entry;
    logic               w_enter_finish, w_fail;

    assign w_start_ok = (r_state == ST_IDLE) & start & ~abort;
    assign w_abort    = (r_state != ST_IDLE) & abort;
    assign w_clear    = w_start_ok | w_abort;
    assign w_last     = (r_addr == {ADDR_W{1'b1}});
    assign w_en       = (r_state == ST_LOAD) & ~abort;

    wave_byte_unpack u_unpack (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_en),
        .i_clear  (w_clear),
        .i_last   (w_last),
        .i_valid  (s_valid),
        .i_data   (s_data),
        .o_ready  (s_ready),
        .o_accept (w_accept),
        .o_wr     (w_wr),
        .o_entry  (w_entry)
    );

`ifdef WAVEFORM_VERIFY_EN
    // Readback: issue reads 0..max, data lands one cycle later and is repacked.
    logic [ADDR_W:0] r_vcnt;
    logic            r_rd_vld;
    logic [1:0]      r_rd_slot;
    logic [5:0]      r_pack;
    logic [15:0]     r_vsum;
    logic            r_error;
    logic            w_vdone, w_mismatch;
    logic [7:0]      w_byte;

    assign w_vdone        = (r_state == ST_VERIFY) & r_vcnt[ADDR_W];
    assign w_byte         = {lut_dout, r_pack};
    assign w_mismatch     = (16'(r_vsum + {8'h00, w_byte}) != r_checksum);
    assign w_enter_finish = w_vdone & ~abort;
    assign w_fail         = w_mismatch;
    assign lut_addr       = (r_state == ST_VERIFY) ? r_vcnt[ADDR_W-1:0] : r_addr;
    assign error          = r_error;

    always_ff @(posedge clk) begin
        if (rst || r_state != ST_VERIFY) begin
            r_vcnt    <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_slot <= 2'd0;
            r_pack    <= 6'd0;
            r_vsum    <= 16'h0000;
        end else begin
            if (!r_vcnt[ADDR_W])
                r_vcnt <= r_vcnt + 1'b1;
            r_rd_vld  <= ~r_vcnt[ADDR_W];
            r_rd_slot <= r_vcnt[1:0];
            if (r_rd_vld) begin
                if (r_rd_slot == 2'd3)
                    r_vsum <= r_vsum + {8'h00, w_byte};
                else
                    r_pack[{r_rd_slot, 1'b0} +: 2] <= lut_dout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_start_ok)
            r_error <= 1'b0;
        else if (w_enter_finish && w_mismatch)
            r_error <= 1'b1;
    end
`else
    logic w_unused_dout;

    assign w_unused_dout  = ^lut_dout;
    assign w_enter_finish = (r_state == ST_LOAD) & w_wr & w_last & ~abort;
    assign w_fail         = 1'b0;
    assign lut_addr       = r_addr;
    assign error          = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        w_busy = (r_state != ST_IDLE);
        w_done = 1'b0;
        case (r_state)
            ST_IDLE:   if (w_start_ok) w_next = ST_LOAD;
            ST_LOAD:   if (w_wr && w_last) begin
`ifdef WAVEFORM_VERIFY_EN
                           w_next = ST_VERIFY;
`else
                           w_next = ST_FINISH;
`endif
                       end
`ifdef WAVEFORM_VERIFY_EN
            ST_VERIFY: if (w_vdone) w_next = ST_FINISH;
`endif
            ST_FINISH: begin
                w_next = ST_IDLE;
                w_done = ~abort;
            end
            default:   w_next = ST_IDLE;
        endcase
        if (w_abort)
            w_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_checksum    <= 16'h0000;
            r_table_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start_ok) begin
                r_addr        <= '0;
                r_checksum    <= 16'h0000;
                r_table_valid <= 1'b0;
            end else begin
                if (w_wr)
                    r_addr <= r_addr + 1'b1;
                if (w_accept)
                    r_checksum <= r_checksum + {8'h00, s_data};
                if (w_abort)
                    r_table_valid <= 1'b0;
                else if (w_enter_finish)
                    r_table_valid <= ~w_fail;
            end
        end
    end

    assign lut_we      = w_wr;
    assign lut_din     = w_entry;
    assign busy        = w_busy;
    assign done        = w_done;
    assign table_valid = r_table_valid;
    assign checksum    = r_checksum;

endmodule

// File: tb/tb_waveform_loader.sv
// Directed bench for waveform_loader: LUT model, write scoreboard, table vectors and corner sequences.
module tb_waveform_loader;
    import waveform_defs::*;

    localparam int AW = LUT_ADDR_W;

    logic          clk = 1'b0;
    logic          rst, start, abort, s_valid, s_ready;
    logic [7:0]    s_data;
    logic          lut_we, busy, done, table_valid, error;
    logic [AW-1:0] lut_addr;
    logic [1:0]    lut_din, lut_dout;
    logic [15:0]   checksum;

    waveform_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .lut_we(lut_we), .lut_addr(lut_addr), .lut_din(lut_din), .lut_dout(lut_dout),
        .busy(busy), .done(done), .table_valid(table_valid), .error(error),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    logic [1:0] lut [LUT_DEPTH];
    initial for (int i = 0; i < LUT_DEPTH; i++) lut[i] = 2'd1;
    always @(posedge clk) begin
        if (lut_we) lut[lut_addr] <= lut_din;
        lut_dout <= lut[lut_addr];
    end

    // Scoreboard: expected write stream from accepted bytes.
    logic [1:0]    q[$];
    logic [AW-1:0] exp_addr = '0;
    int sb_bad = 0, wr_cnt = 0, acc_cnt = 0, done_cnt = 0;
    always @(posedge clk) begin
        logic [1:0] e;
        if (rst) begin
            q.delete();
            exp_addr = '0;
        end else begin
            if (s_ready && !(q.size() == 0 || (q.size() == 1 && lut_we))) sb_bad++;
            if (s_ready && lut_we && lut_addr == {AW{1'b1}}) sb_bad++;
            if (lut_we) begin
                wr_cnt++;
                if (q.size() == 0) sb_bad++;
                else begin
                    e = q.pop_front();
                    if (e != lut_din) sb_bad++;
                end
                if (lut_addr != exp_addr) sb_bad++;
                exp_addr = exp_addr + 1'b1;
            end
            if (s_valid && s_ready) begin
                acc_cnt++;
                for (int i = 0; i < 4; i++) q.push_back(s_data[2*i +: 2]);
            end
            if (done) done_cnt++;
            if (start && !abort && !busy) begin q.delete(); exp_addr = '0; end
            if (abort && busy) q.delete();
        end
    end

    int n_cmp = 0, n_err = 0, send_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap);
        bit ok = 0;
        s_valid = 1'b0;
        repeat (gap) tick();
        s_data = d; s_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (s_ready) begin ok = 1; tick(); break; end
            tick();
        end
        s_valid = 1'b0;
        if (!ok) send_fail++;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_tvalid"}, 32'(table_valid), 0);
        check({tag, "_error"}, 32'(error), 0);
        check({tag, "_sready"}, 32'(s_ready), 0);
        check({tag, "_we"}, 32'(lut_we), 0);
        check({tag, "_addr"}, 32'(lut_addr), 0);
        check({tag, "_csum"}, 32'(checksum), 0);
    endtask

    typedef struct {
        logic [7:0] data;
        int         gap;
        logic [1:0] e0, e1, e2, e3;
    } vec_t;

    vec_t vec [8];

    initial begin
        int d0, w0, a0, bad, cyc;
        logic [15:0] sum;
        logic [7:0]  rb;

        vec[0] = '{8'h1B, 0, 2'd3, 2'd2, 2'd1, 2'd0};
        vec[1] = '{8'hE4, 3, 2'd0, 2'd1, 2'd2, 2'd3};
        vec[2] = '{8'h00, 0, 2'd0, 2'd0, 2'd0, 2'd0};
        vec[3] = '{8'hFF, 5, 2'd3, 2'd3, 2'd3, 2'd3};
        vec[4] = '{8'h55, 1, 2'd1, 2'd1, 2'd1, 2'd1};
        vec[5] = '{8'hAA, 0, 2'd2, 2'd2, 2'd2, 2'd2};
        vec[6] = '{8'h96, 7, 2'd2, 2'd1, 2'd1, 2'd2};
        vec[7] = '{8'h3C, 2, 2'd0, 2'd3, 2'd3, 2'd0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        repeat (3) tick();
        check_zero("rst");
        rst = 1'b0; tick();
        check_zero("idle");

        // Table vectors with stalls between bytes
        d0 = done_cnt;
        pulse_start();
        check("t_busy", 32'(busy), 1);
        check("t_sready", 32'(s_ready), 1);
        for (int k = 0; k < 8; k++) send_byte(vec[k].data, vec[k].gap);
        repeat (8) tick();
        check("t_addr", 32'(lut_addr), 32);
        check("t_csum", 32'(checksum), 32'h03CF);
        check("t_stall_we", 32'(lut_we), 0);
        for (int k = 0; k < 8; k++)
            check($sformatf("t_vec%0d", k),
                  {24'd0, lut[4*k+3], lut[4*k+2], lut[4*k+1], lut[4*k]},
                  {24'd0, vec[k].e3, vec[k].e2, vec[k].e1, vec[k].e0});
        start = 1'b1; tick(); start = 1'b0; tick();
        check("busystart_addr", 32'(lut_addr), 32);
        check("busystart_csum", 32'(checksum), 32'h03CF);
        check("busystart_busy", 32'(busy), 1);
        abort = 1'b1; tick(); abort = 1'b0;
        check("t_abort_busy", 32'(busy), 0);
        check("t_abort_tvalid", 32'(table_valid), 0);
        check("t_abort_csum", 32'(checksum), 32'h03CF);
        check("t_abort_nodone", 32'(done_cnt - d0), 0);

        // abort wins over start in IDLE
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        check("abort_start_busy", 32'(busy), 0);
        tick();
        check("abort_start_busy2", 32'(busy), 0);

        // 100 random bytes with random gaps, then abort
        d0 = done_cnt; w0 = wr_cnt; a0 = acc_cnt; sum = 16'h0;
        pulse_start();
        check("r_csum_clr", 32'(checksum), 0);
        for (int k = 0; k < 100; k++) begin
            rb = 8'($urandom);
            sum = sum + {8'h00, rb};
            send_byte(rb, int'($urandom_range(0, 4)));
        end
        repeat (6) tick();
        check("r_writes", 32'(wr_cnt - w0), 400);
        check("r_accepts", 32'(acc_cnt - a0), 100);
        check("r_csum", 32'(checksum), 32'(sum));
        abort = 1'b1; tick(); abort = 1'b0;
        check("r_abort_busy", 32'(busy), 0);
        check("r_abort_tvalid", 32'(table_valid), 0);
        check("r_abort_sready", 32'(s_ready), 0);
        check("r_abort_nodone", 32'(done_cnt - d0), 0);

        // Full table of 0x1B, s_valid held high
        d0 = done_cnt; w0 = wr_cnt; a0 = acc_cnt;
        pulse_start();
        s_data = 8'h1B; s_valid = 1'b1;
        cyc = 0;
        while (!done && cyc < 20000) begin tick(); cyc++; end
        check("f_done_seen", 32'(done), 1);
        check("f_tvalid_at_done", 32'(table_valid), 1);
        check("f_csum", 32'(checksum), 32'hB000);
        check("f_writes", 32'(wr_cnt - w0), 16384);
        check("f_accepts", 32'(acc_cnt - a0), 4096);
        check("f_sready_end", 32'(s_ready), 0);
        tick();
        s_valid = 1'b0;
        check("f_done_pulse", 32'(done), 0);
        check("f_busy_end", 32'(busy), 0);
        check("f_tvalid", 32'(table_valid), 1);
        check("f_addr_wrap", 32'(lut_addr), 0);
        check("f_done_cnt", 32'(done_cnt - d0), 1);
        check("f_error", 32'(error), 0);
        bad = 0;
        for (int i = 0; i < LUT_DEPTH; i++) if (lut[i] != 2'(3 - (i % 4))) bad++;
        check("f_lut_pattern", 32'(bad), 0);

        // Reset mid-load, then reload from address 0
        pulse_start();
        check("m_tvalid_clr", 32'(table_valid), 0);
        s_data = 8'h77; s_valid = 1'b1;
        repeat (10) tick();
        s_valid = 1'b0; rst = 1'b1; tick();
        check_zero("midrst");
        rst = 1'b0; tick();
        pulse_start();
        send_byte(8'hE4, 0);
        repeat (6) tick();
        check("m_reload",
              {24'd0, lut[3], lut[2], lut[1], lut[0]},
              {24'd0, 2'd3, 2'd2, 2'd1, 2'd0});
        check("m_addr", 32'(lut_addr), 4);
        check("m_csum", 32'(checksum), 32'h00E4);
        abort = 1'b1; tick(); abort = 1'b0;
        check("m_abort_busy", 32'(busy), 0);

        check("send_timeouts", 32'(send_fail), 0);
        check("scoreboard", 32'(sb_bad), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
